// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the 16-bit RISC CPU controller: instruction fields,
// datapath select codes, memory commands and the controller state type.
package cpu_ctrl_pkg;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_SHF = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_MDATA  = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC     = 2'b10;
  localparam logic [1:0] VSEL_C      = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_IF1     = 5'd1,
    S_IF2     = 5'd2,
    S_UPDPC   = 5'd3,
    S_DECODE  = 5'd4,
    S_WIMM    = 5'd5,
    S_GETA    = 5'd6,
    S_GETB    = 5'd7,
    S_EXE     = 5'd8,
    S_EXZ     = 5'd9,
    S_EXS     = 5'd10,
    S_WB      = 5'd11,
    S_ADR     = 5'd12,
    S_LADR    = 5'd13,
    S_ASET    = 5'd14,
    S_MRD     = 5'd15,
    S_LWB     = 5'd16,
    S_SGETB   = 5'd17,
    S_SPASS   = 5'd18,
    S_MWR     = 5'd19,
    S_HALT    = 5'd20,
    S_ILLEGAL = 5'd21
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that paces RAM read waits: loaded on entry to a wait state,
// decremented while waiting, zero flag tells the FSM the data is valid.
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_control_fsm.sv
// Moore controller for the 16-bit RISC CPU: fetch, PC update, decode and
// execution of MOV/ALU/LDR/STR/HALT with a configurable RAM read latency.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter bit ENABLE_HALT = 1'b1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       loadir,
  output logic       loadpc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output state_t     dbg_state
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);

  state_t state_q, state_d;
  logic   cnt_load, cnt_dec, cnt_zero;

  // Wait states load the counter on entry so residency is exactly MEM_LAT.
  assign cnt_load = ((state_d == S_IF1) || (state_d == S_MRD)) && (state_d != state_q);
  assign cnt_dec  = (state_q == S_IF1) || (state_q == S_MRD);

  mem_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    if (cnt_zero) state_d = S_IF2;
      S_IF2:    state_d = S_UPDPC;
      S_UPDPC:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_MOV: begin
            if (op == OP_MOV_IMM)      state_d = S_WIMM;
            else if (op == OP_MOV_SHF) state_d = S_GETB;
            else                       state_d = S_ILLEGAL;
          end
          OPC_ALU:  state_d = (op == OP_MVN) ? S_GETB : S_GETA;
          OPC_LDR:  state_d = (op == OP_MEM) ? S_GETA : S_ILLEGAL;
          OPC_STR:  state_d = (op == OP_MEM) ? S_GETA : S_ILLEGAL;
          OPC_HALT: state_d = ENABLE_HALT ? S_HALT : S_ILLEGAL;
          default:  state_d = S_ILLEGAL;
        endcase
      end
      S_WIMM:   state_d = S_IF1;
      S_GETA:   state_d = ((opcode == OPC_LDR) || (opcode == OPC_STR)) ? S_ADR : S_GETB;
      S_GETB: begin
        // MOV shift and MVN have no A operand, so they use the zeroed-A execute.
        if ((opcode == OPC_ALU) && (op == OP_CMP))                   state_d = S_EXS;
        else if ((opcode == OPC_MOV) || ((opcode == OPC_ALU) && (op == OP_MVN))) state_d = S_EXZ;
        else                                                         state_d = S_EXE;
      end
      S_EXE:    state_d = S_WB;
      S_EXZ:    state_d = S_WB;
      S_EXS:    state_d = S_IF1;
      S_WB:     state_d = S_IF1;
      S_ADR:    state_d = S_LADR;
      S_LADR:   state_d = S_ASET;
      S_ASET:   state_d = (opcode == OPC_LDR) ? S_MRD : S_SGETB;
      S_MRD:    if (cnt_zero) state_d = S_LWB;
      S_LWB:    state_d = S_IF1;
      S_SGETB:  state_d = S_SPASS;
      S_SPASS:  state_d = S_MWR;
      S_MWR:    state_d = S_IF1;
      S_HALT:   state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:  state_d = S_ILLEGAL;
    endcase
  end

  always_comb begin
    nsel      = NSEL_RN;
    vsel      = VSEL_MDATA;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    loadir    = 1'b0;
    loadpc    = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    busy      = 1'b1;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_RST:   begin reset_pc = 1'b1; loadpc = 1'b1; end
      S_IF1:   begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      S_IF2:   begin addr_sel = 1'b1; mem_cmd = MEM_READ; loadir = 1'b1; end
      S_UPDPC: loadpc = 1'b1;
      S_WIMM:  begin nsel = NSEL_RN; vsel = VSEL_SXIMM8; write = 1'b1; end
      S_GETA:  begin nsel = NSEL_RN; loada = 1'b1; end
      S_GETB:  begin nsel = NSEL_RM; loadb = 1'b1; end
      S_EXE:   loadc = 1'b1;
      S_EXZ:   begin asel = 1'b1; loadc = 1'b1; end
      S_EXS:   loads = 1'b1;
      S_WB:    begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
      S_ADR:   begin bsel = 1'b1; loadc = 1'b1; end
      S_LADR:  load_addr = 1'b1;
      S_MRD:   mem_cmd = MEM_READ;
      S_LWB:   begin mem_cmd = MEM_READ; nsel = NSEL_RD; vsel = VSEL_MDATA; write = 1'b1; end
      S_SGETB: begin nsel = NSEL_RD; loadb = 1'b1; end
      S_SPASS: begin asel = 1'b1; loadc = 1'b1; end
      S_MWR:   mem_cmd = MEM_WRITE;
      S_HALT:  begin busy = 1'b0; halted = 1'b1; end
      S_ILLEGAL: begin busy = 1'b0; illegal = 1'b1; end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Parametrised Moore controller for the 16-bit RISC CPU.
- Sequences fetch, PC update, decode and execute of MOV, ALU, LDR, STR and HALT.
- Drives the existing decoder, datapath, program counter, address register, RAM and instruction register.
- Successor to the fixed-timing controller: adds configurable RAM read latency, full LDR/STR sequencing, HALT, illegal-opcode trapping and a busy/halted status interface.

Parameters:
- MEM_LAT, 1, RAM cycles from address stable to mdata valid; legal range 1..15.
- ENABLE_HALT, 1, 1 = opcode 3'b111 halts; 0 = opcode 3'b111 is illegal.
- CNT_W, 4, width of the memory wait counter; must satisfy MEM_LAT < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- opcode  in  3  instruction register [15:13].
- op  in  2  instruction register [12:11].
- nsel  out  2  register select: 00 Rn, 01 Rd, 10 Rm.
- vsel  out  2  writeback source: 00 mdata, 01 sximm8, 10 {8'b0,PC}, 11 C.
- loada, loadb, asel, bsel, loadc, loads, write  out  1 each  datapath controls.
- loadir  out  1  instruction register enable.
- loadpc  out  1  PC load enable.
- reset_pc  out  1  PC load value = 0 (else PC+1).
- addr_sel  out  1  memory address source: 1 PC, 0 address register.
- load_addr  out  1  address register loads C[8:0].
- mem_cmd  out  2  00 none, 01 read, 10 write; 11 never driven.
- busy  out  1  high in every state except HALT and ILLEGAL.
- halted  out  1  in HALT.
- illegal  out  1  in ILLEGAL.

Behaviour:
- Moore machine: every output is a function of the state register only. Default for every output is 0 / 2'b00; each state drives only what it lists.
- reset (synchronous, any state, including mid-wait): next state RST, wait counter cleared.
- RST: reset_pc=1, loadpc=1. Next: IF1.
- IF1: addr_sel=1, mem_cmd=01. Loads wait counter with MEM_LAT-1. Stays while counter≠0, decrementing each cycle. Total IF1 residency is exactly MEM_LAT cycles, then IF2.
- IF2: addr_sel=1, mem_cmd=01, loadir=1. Next: UPDPC.
- UPDPC: loadpc=1, reset_pc=0. Next: DECODE.
- DECODE: no controls asserted. Branches on {opcode, op}. Any unlisted combination goes to ILLEGAL.
- MOV imm (110,10): WIMM (nsel=Rn, vsel=01, write=1) → IF1.
- MOV shift (110,00): GETB (nsel=Rm, loadb=1) → EXE (asel=1, bsel=0, loadc=1) → WB (nsel=Rd, vsel=11, write=1) → IF1.
- ADD/AND (101,00 / 101,10): GETA (nsel=Rn, loada=1) → GETB → EXE (asel=0, bsel=0, loadc=1) → WB → IF1.
- CMP (101,01): GETA → GETB → EXS (asel=0, bsel=0, loads=1) → IF1. No register write.
- MVN (101,11): GETB → EXE (asel=1) → WB → IF1.
- LDR (011,00): GETA → ADR (asel=0, bsel=1, loadc=1) → LADR (load_addr=1) → MRD (addr_sel=0, mem_cmd=01, MEM_LAT cycles, same counter rule as IF1) → LWB (addr_sel=0, mem_cmd=01, nsel=Rd, vsel=00, write=1) → IF1.
- STR (100,00): GETA → ADR → LADR → SGETB (nsel=Rd, loadb=1) → SPASS (asel=1, bsel=0, loadc=1) → MWR (addr_sel=0, mem_cmd=10, one cycle) → IF1.
- HALT (111,xx, ENABLE_HALT=1): HALT state, busy=0, halted=1. Exits only on reset.
- ILLEGAL: busy=0, illegal=1. Exits only on reset.
- Latencies in clocks, from IF1 entry to next IF1 entry (M = MEM_LAT):
  - MOV imm: M+4
  - MOV shift, MVN: M+6
  - ADD, AND: M+7
  - CMP: M+6
  - LDR: 2M+8
  - STR: M+10
- Control state is shared across opcodes: GETA/GETB/EXE/WB are single states, and the path decision is taken from the live opcode/op, which the IR holds stable because loadir=0 outside IF2.
- mem_cmd=10 is asserted for exactly one cycle per STR.
- write and mem_cmd=10 are never high in the same cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants (MOV 110, ALU 101, STR 100, LDR 011, HALT 111);
  - op constants (ADD 00, CMP 01, AND 10, MVN 11);
  - nsel constants (RN, RD, RM);
  - vsel constants (MDATA, SXIMM8, PC, C);
  - mem_cmd constants;
  - 5-bit state encoding typedef.
- One sub-module, mem_wait_counter: load value, decrement, and a zero flag, CNT_W wide. The FSM uses a single instance for both IF1 and MRD.

Test Plan:
- reset held 3 cycles, then released → RST, then IF1. With MEM_LAT=1, loadir is high on cycle 2 after release and loadpc is high on cycle 3 with reset_pc=0.
- MOV R0,#7 (110,10), MEM_LAT=1 → WIMM asserts nsel=00, vsel=01, write=1 for one cycle; IF1 is re-entered 5 cycles after the first IF1.
- ADD (101,00) then CMP (101,01) → ADD shows loada, loadb, loadc, write in order with period 8. CMP shows loads=1 exactly once and write is never asserted.
- LDR with MEM_LAT=3 → MRD holds mem_cmd=01 and addr_sel=0 for 3 cycles. LWB write=1 with vsel=00. Total 14 cycles.
- STR, then reset asserted during MWR → mem_cmd=10 lasts one cycle; the next state is RST, with reset_pc=1 and loadpc=1.
- opcode 111: with ENABLE_HALT=1 → halted=1, busy=0, held 20 cycles with no load asserted. With ENABLE_HALT=0, or opcode 000 → illegal=1.
